// File: rtl/softmax_row_sched.sv
// Row scheduler: runs one softmax pass per row and rebases the engine's read addresses onto the row base.
// Latency: cfg_start -> sm_start 1 cycle; sampled done edge -> next sm_start 2 cycles; mem_* combinational.
// Backpressure: one row in flight; a fresh sm_done edge gates progress and the watchdog bounds a stalled row.
module softmax_row_sched #(
    parameter int ADDRSIZE = 16,
    parameter int ROWCNT_W = 8,
    parameter int TIMEOUT  = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_start,
    input  logic [ADDRSIZE-1:0] cfg_base_addr,
    input  logic [ADDRSIZE-1:0] cfg_stride,
    input  logic [ADDRSIZE-1:0] cfg_addr_limit,
    input  logic [ROWCNT_W-1:0] cfg_num_rows,
    input  logic                abort,
    output logic                sm_start,
    output logic [ADDRSIZE-1:0] sm_addr_limit,
    input  logic                sm_done,
    input  logic [ADDRSIZE-1:0] sm_addr,
    input  logic [ADDRSIZE-1:0] sm_sub0_addr,
    input  logic [ADDRSIZE-1:0] sm_sub1_addr,
    output logic [ADDRSIZE-1:0] mem_addr,
    output logic [ADDRSIZE-1:0] mem_sub0_addr,
    output logic [ADDRSIZE-1:0] mem_sub1_addr,
    output logic [ROWCNT_W-1:0] row_idx,
    output logic                busy,
    output logic                batch_done,
    output logic                err
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_NEXT, S_FINISH} state_t;

    typedef struct packed {
        logic [ADDRSIZE-1:0] stride;
        logic [ROWCNT_W-1:0] num_rows;
    } cfg_t;

    state_t              state_q, state_d;
    cfg_t                cfg_q;
    logic [ADDRSIZE-1:0] row_base_q;
    logic [WD_W-1:0]     wdog_q;
    logic                sm_done_q;
    logic                done_rise;
    logic                accept;
    logic                adv;
    logic                timeout_hit;

    assign done_rise = sm_done & ~sm_done_q;
    assign busy      = (state_q != S_IDLE);

    assign mem_addr      = row_base_q + sm_addr;
    assign mem_sub0_addr = row_base_q + sm_sub0_addr;
    assign mem_sub1_addr = row_base_q + sm_sub1_addr;

    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        adv         = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    accept  = 1'b1;
                    state_d = (cfg_num_rows == '0) ? S_FINISH : S_LAUNCH;
                end
            end
            S_LAUNCH: state_d = S_WAIT;
            S_WAIT: begin
                // A done edge in the same cycle as expiry wins: the row did finish.
                if (done_rise) begin
                    state_d = S_NEXT;
                end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_d     = S_FINISH;
                end
            end
            S_NEXT: begin
                if (row_idx == cfg_q.num_rows - ROWCNT_W'(1)) begin
                    state_d = S_FINISH;
                end else begin
                    adv     = 1'b1;
                    state_d = S_LAUNCH;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (abort && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            adv         = 1'b0;
            timeout_hit = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cfg_q         <= '0;
            row_base_q    <= '0;
            row_idx       <= '0;
            sm_addr_limit <= '0;
            wdog_q        <= '0;
            sm_done_q     <= 1'b1;
            sm_start      <= 1'b0;
            batch_done    <= 1'b0;
            err           <= 1'b0;
        end else begin
            state_q    <= state_d;
            sm_start   <= (state_d == S_LAUNCH);
            batch_done <= (state_d == S_FINISH);
            // Masking the edge detector at launch hides a done level left over from the previous row.
            sm_done_q  <= (state_q == S_LAUNCH) ? 1'b1 : sm_done;
            if (accept) begin
                cfg_q         <= '{stride: cfg_stride, num_rows: cfg_num_rows};
                sm_addr_limit <= cfg_addr_limit;
                row_base_q    <= cfg_base_addr;
                row_idx       <= '0;
                err           <= 1'b0;
            end
            if (adv) begin
                row_idx    <= row_idx + ROWCNT_W'(1);
                row_base_q <= row_base_q + cfg_q.stride;
            end
            if (state_q == S_LAUNCH) begin
                wdog_q <= '0;
            end else if (state_q == S_WAIT) begin
                wdog_q <= wdog_q + WD_W'(1);
            end
            if (timeout_hit) begin
                err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_softmax_row_sched.sv
// Directed bench for softmax_row_sched: a long-timeout instance for normal flows and a TIMEOUT=16 instance for the watchdog.
module tb_softmax_row_sched;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_start = 1'b0, wd_cfg_start = 1'b0;
    logic [15:0] cfg_base_addr = '0, cfg_stride = '0, cfg_addr_limit = '0;
    logic [7:0]  cfg_num_rows = '0;
    logic        abort = 1'b0, wd_abort = 1'b0;
    logic        sm_done = 1'b0, wd_sm_done = 1'b0;
    logic [15:0] sm_addr = '0, sm_sub0_addr = '0, sm_sub1_addr = '0;

    logic        sm_start, busy, batch_done, err;
    logic [15:0] sm_addr_limit, mem_addr, mem_sub0_addr, mem_sub1_addr;
    logic [7:0]  row_idx;
    logic        wd_sm_start, wd_busy, wd_batch_done, wd_err;
    logic [15:0] wd_sm_addr_limit, wd_mem_addr, wd_mem_sub0_addr, wd_mem_sub1_addr;
    logic [7:0]  wd_row_idx;

    int checks = 0;
    int passed = 0;

    softmax_row_sched #(.ADDRSIZE(16), .ROWCNT_W(8), .TIMEOUT(1024)) dut (
        .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr),
        .cfg_stride(cfg_stride), .cfg_addr_limit(cfg_addr_limit), .cfg_num_rows(cfg_num_rows),
        .abort(abort), .sm_start(sm_start), .sm_addr_limit(sm_addr_limit), .sm_done(sm_done),
        .sm_addr(sm_addr), .sm_sub0_addr(sm_sub0_addr), .sm_sub1_addr(sm_sub1_addr),
        .mem_addr(mem_addr), .mem_sub0_addr(mem_sub0_addr), .mem_sub1_addr(mem_sub1_addr),
        .row_idx(row_idx), .busy(busy), .batch_done(batch_done), .err(err)
    );

    softmax_row_sched #(.ADDRSIZE(16), .ROWCNT_W(8), .TIMEOUT(16)) dut_wd (
        .clk(clk), .reset(reset), .cfg_start(wd_cfg_start), .cfg_base_addr(cfg_base_addr),
        .cfg_stride(cfg_stride), .cfg_addr_limit(cfg_addr_limit), .cfg_num_rows(cfg_num_rows),
        .abort(wd_abort), .sm_start(wd_sm_start), .sm_addr_limit(wd_sm_addr_limit), .sm_done(wd_sm_done),
        .sm_addr(sm_addr), .sm_sub0_addr(sm_sub0_addr), .sm_sub1_addr(sm_sub1_addr),
        .mem_addr(wd_mem_addr), .mem_sub0_addr(wd_mem_sub0_addr), .mem_sub1_addr(wd_mem_sub1_addr),
        .row_idx(wd_row_idx), .busy(wd_busy), .batch_done(wd_batch_done), .err(wd_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_batch(input bit wd, input logic [15:0] base, input logic [15:0] stride,
                               input logic [15:0] limit, input logic [7:0] rows);
        cfg_base_addr  = base;
        cfg_stride     = stride;
        cfg_addr_limit = limit;
        cfg_num_rows   = rows;
        if (wd) wd_cfg_start = 1'b1;
        else    cfg_start    = 1'b1;
        tick();
        cfg_start    = 1'b0;
        wd_cfg_start = 1'b0;
    endtask

    task automatic test_reset();
        sm_addr = 16'h0042; sm_sub0_addr = 16'h0007; sm_sub1_addr = 16'h1234;
        #2;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        checks++; if (sm_start !== 1'b0) $display("FAIL reset_sm_start got %b want 0", sm_start); else passed++;
        checks++; if (batch_done !== 1'b0) $display("FAIL reset_batch_done got %b want 0", batch_done); else passed++;
        checks++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else passed++;
        checks++; if (row_idx !== 8'd0) $display("FAIL reset_row_idx got %0d want 0", row_idx); else passed++;
        checks++; if (sm_addr_limit !== 16'h0) $display("FAIL reset_limit got %h want 0000", sm_addr_limit); else passed++;
        checks++; if (mem_addr !== 16'h0042) $display("FAIL reset_mem_addr got %h want 0042", mem_addr); else passed++;
        checks++; if (mem_sub0_addr !== 16'h0007) $display("FAIL reset_mem_sub0 got %h want 0007", mem_sub0_addr); else passed++;
        checks++; if (mem_sub1_addr !== 16'h1234) $display("FAIL reset_mem_sub1 got %h want 1234", mem_sub1_addr); else passed++;
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_row();
        int starts;
        sm_addr = 16'h0003;
        start_batch(1'b0, 16'h0000, 16'd5, 16'd4, 8'd1);
        starts = sm_start ? 1 : 0;
        checks++; if (sm_addr_limit !== 16'd4) $display("FAIL single_limit got %0d want 4", sm_addr_limit); else passed++;
        checks++; if (mem_addr !== 16'h0003) $display("FAIL single_mem_addr got %h want 0003", mem_addr); else passed++;
        for (int i = 0; i < 19; i++) begin
            tick();
            if (sm_start) starts++;
        end
        sm_done = 1'b1;
        tick();
        checks++; if (batch_done !== 1'b0) $display("FAIL single_early_done got %b want 0", batch_done); else passed++;
        tick();
        sm_done = 1'b0;
        checks++; if (batch_done !== 1'b1) $display("FAIL single_batch_done got %b want 1", batch_done); else passed++;
        checks++; if (err !== 1'b0) $display("FAIL single_err got %b want 0", err); else passed++;
        checks++; if (starts !== 1) $display("FAIL single_start_count got %0d want 1", starts); else passed++;
        tick();
        checks++; if (batch_done !== 1'b0) $display("FAIL single_done_pulse got %b want 0", batch_done); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL single_busy_end got %b want 0", busy); else passed++;
    endtask

    task automatic test_three_rows();
        logic [15:0] exp;
        sm_sub0_addr = 16'h0020; sm_sub1_addr = 16'h0031;
        start_batch(1'b0, 16'h0100, 16'h0010, 16'd4, 8'd3);
        for (int r = 0; r < 3; r++) begin
            checks++; if (sm_start !== 1'b1) $display("FAIL three_start row %0d got %b want 1", r, sm_start); else passed++;
            checks++; if (row_idx !== 8'(r)) $display("FAIL three_row_idx got %0d want %0d", row_idx, r); else passed++;
            for (int a = 0; a < 5; a++) begin
                sm_addr = 16'(a);
                #1;
                exp = 16'h0100 + 16'(16 * r) + 16'(a);
                checks++; if (mem_addr !== exp) $display("FAIL three_mem_addr got %h want %h", mem_addr, exp); else passed++;
            end
            exp = 16'h0120 + 16'(16 * r);
            checks++; if (mem_sub0_addr !== exp) $display("FAIL three_mem_sub0 got %h want %h", mem_sub0_addr, exp); else passed++;
            exp = 16'h0131 + 16'(16 * r);
            checks++; if (mem_sub1_addr !== exp) $display("FAIL three_mem_sub1 got %h want %h", mem_sub1_addr, exp); else passed++;
            tick(); tick(); tick();
            sm_done = 1'b1;
            tick();
            sm_done = 1'b0;
            checks++; if (sm_start !== 1'b0) $display("FAIL three_gap_next got %b want 0", sm_start); else passed++;
            tick();
        end
        checks++; if (batch_done !== 1'b1) $display("FAIL three_batch_done got %b want 1", batch_done); else passed++;
        checks++; if (sm_start !== 1'b0) $display("FAIL three_extra_start got %b want 0", sm_start); else passed++;
        tick();
        checks++; if (busy !== 1'b0) $display("FAIL three_busy_end got %b want 0", busy); else passed++;
    endtask

    task automatic test_stale_done();
        bit saw_done;
        saw_done = 1'b0;
        start_batch(1'b0, 16'h0000, 16'h0040, 16'd4, 8'd2);
        tick(); tick();
        sm_done = 1'b1;
        tick(); tick();
        checks++; if (sm_start !== 1'b1 || row_idx !== 8'd1) $display("FAIL stale_row1_launch got start=%b idx=%0d want 1/1", sm_start, row_idx); else passed++;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (batch_done) saw_done = 1'b1;
        end
        checks++; if (saw_done !== 1'b0) $display("FAIL stale_skipped got batch_done=%b want 0", saw_done); else passed++;
        checks++; if (busy !== 1'b1) $display("FAIL stale_busy got %b want 1", busy); else passed++;
        sm_done = 1'b0;
        tick();
        sm_done = 1'b1;
        tick(); tick();
        sm_done = 1'b0;
        checks++; if (batch_done !== 1'b1) $display("FAIL stale_batch_done got %b want 1", batch_done); else passed++;
        tick();
    endtask

    task automatic test_wrap();
        sm_addr = 16'h0003;
        start_batch(1'b0, 16'hFFF8, 16'd8, 16'd4, 8'd2);
        #1;
        checks++; if (mem_addr !== 16'hFFFB) $display("FAIL wrap_row0 got %h want fffb", mem_addr); else passed++;
        tick(); tick();
        sm_done = 1'b1;
        tick();
        sm_done = 1'b0;
        tick();
        checks++; if (mem_addr !== 16'h0003) $display("FAIL wrap_row1 got %h want 0003", mem_addr); else passed++;
        tick(); tick();
        sm_done = 1'b1;
        tick(); tick();
        sm_done = 1'b0;
        checks++; if (batch_done !== 1'b1) $display("FAIL wrap_batch_done got %b want 1", batch_done); else passed++;
        tick();
    endtask

    task automatic test_zero_rows();
        start_batch(1'b0, 16'h0500, 16'd1, 16'd4, 8'd0);
        checks++; if (batch_done !== 1'b1) $display("FAIL zero_batch_done got %b want 1", batch_done); else passed++;
        checks++; if (sm_start !== 1'b0) $display("FAIL zero_sm_start got %b want 0", sm_start); else passed++;
        tick();
        checks++; if (busy !== 1'b0 || batch_done !== 1'b0) $display("FAIL zero_idle got busy=%b done=%b want 0/0", busy, batch_done); else passed++;
    endtask

    task automatic test_abort();
        start_batch(1'b0, 16'h0000, 16'd8, 16'd4, 8'd2);
        tick(); tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else passed++;
        checks++; if (batch_done !== 1'b0) $display("FAIL abort_batch_done got %b want 0", batch_done); else passed++;
        checks++; if (err !== 1'b0) $display("FAIL abort_err got %b want 0", err); else passed++;
        tick();
        checks++; if (batch_done !== 1'b0 || sm_start !== 1'b0) $display("FAIL abort_quiet got done=%b start=%b want 0/0", batch_done, sm_start); else passed++;
    endtask

    task automatic test_busy_start();
        sm_addr = 16'h0001;
        start_batch(1'b0, 16'h0200, 16'd8, 16'd9, 8'd1);
        tick(); tick();
        start_batch(1'b0, 16'h0500, 16'd8, 16'h0033, 8'd5);
        checks++; if (sm_addr_limit !== 16'd9) $display("FAIL busy_start_limit got %h want 0009", sm_addr_limit); else passed++;
        checks++; if (mem_addr !== 16'h0201) $display("FAIL busy_start_base got %h want 0201", mem_addr); else passed++;
        checks++; if (sm_start !== 1'b0) $display("FAIL busy_start_relaunch got %b want 0", sm_start); else passed++;
        sm_done = 1'b1;
        tick(); tick();
        sm_done = 1'b0;
        checks++; if (batch_done !== 1'b1) $display("FAIL busy_start_rows got batch_done=%b want 1", batch_done); else passed++;
        tick();
    endtask

    task automatic test_watchdog();
        int late_starts;
        late_starts = 0;
        start_batch(1'b1, 16'h0000, 16'h0010, 16'd4, 8'd4);
        tick(); tick();
        wd_sm_done = 1'b1;
        tick();
        wd_sm_done = 1'b0;
        tick();
        checks++; if (wd_sm_start !== 1'b1 || wd_row_idx !== 8'd1) $display("FAIL wd_row1_launch got start=%b idx=%0d want 1/1", wd_sm_start, wd_row_idx); else passed++;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (wd_sm_start) late_starts++;
        end
        checks++; if (wd_err !== 1'b0) $display("FAIL wd_err_early got %b want 0", wd_err); else passed++;
        tick();
        checks++; if (wd_err !== 1'b1) $display("FAIL wd_err_set got %b want 1", wd_err); else passed++;
        checks++; if (wd_batch_done !== 1'b1) $display("FAIL wd_batch_done got %b want 1", wd_batch_done); else passed++;
        tick();
        if (wd_sm_start) late_starts++;
        checks++; if (wd_busy !== 1'b0 || wd_err !== 1'b1) $display("FAIL wd_sticky got busy=%b err=%b want 0/1", wd_busy, wd_err); else passed++;
        checks++; if (late_starts !== 0 || wd_row_idx !== 8'd1) $display("FAIL wd_rows_skipped got starts=%0d idx=%0d want 0/1", late_starts, wd_row_idx); else passed++;
        start_batch(1'b1, 16'h0000, 16'h0010, 16'd4, 8'd0);
        checks++; if (wd_err !== 1'b0) $display("FAIL wd_err_clear got %b want 0", wd_err); else passed++;
        tick();
    endtask

    task automatic test_async_reset();
        start_batch(1'b0, 16'h0300, 16'h0010, 16'd4, 8'd3);
        tick(); tick();
        sm_done = 1'b1;
        tick();
        sm_done = 1'b0;
        tick(); tick(); tick();
        checks++; if (row_idx !== 8'd1 || busy !== 1'b1) $display("FAIL arst_setup got idx=%0d busy=%b want 1/1", row_idx, busy); else passed++;
        sm_addr = 16'h0002;
        #2;
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) $display("FAIL arst_busy got %b want 0", busy); else passed++;
        checks++; if (row_idx !== 8'd0) $display("FAIL arst_row_idx got %0d want 0", row_idx); else passed++;
        checks++; if (sm_start !== 1'b0) $display("FAIL arst_sm_start got %b want 0", sm_start); else passed++;
        checks++; if (mem_addr !== 16'h0002) $display("FAIL arst_mem_addr got %h want 0002", mem_addr); else passed++;
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_row();
        test_three_rows();
        test_stale_done();
        test_wrap();
        test_zero_rows();
        test_abort();
        test_busy_start();
        test_watchdog();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout got no completion want finish before 200000ns");
        $fatal(1, "simulation time limit reached");
    end
endmodule
